// File: rtl/hamming_rx_ctrl_pkg.sv
// Shared constants, state encoding and syndrome helper
// for the serial Hamming(7,4) receive controller.
package hamming_rx_ctrl_pkg;

    localparam int CW_LEN   = 7;
    localparam int DATA_LEN = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [2:0] syndrome(input logic [CW_LEN-1:0] m);
        return {m[3] ^ m[4] ^ m[5] ^ m[6],
                m[1] ^ m[2] ^ m[5] ^ m[6],
                m[0] ^ m[2] ^ m[4] ^ m[6]};
    endfunction

endpackage

// File: rtl/hamming_rx_ctrl_if.sv
// Serial codeword input and decoded-nibble output bundle
// between a bit source (master) and the controller (slave).
interface hamming_rx_ctrl_if;
    import hamming_rx_ctrl_pkg::*;

    logic                start;
    logic                in_bit;
    logic                in_valid;
    logic [DATA_LEN-1:0] d_out;
    logic                d_valid;
    logic                err_flag;
    logic                busy;

    modport master (
        output start, in_bit, in_valid,
        input  d_out, d_valid, err_flag, busy
    );

    modport slave (
        input  start, in_bit, in_valid,
        output d_out, d_valid, err_flag, busy
    );

endinterface

// File: rtl/hamming_rx_ctrl_receptor.sv
// Combinational Hamming(7,4) decoder: single-bit correction
// of the data nibble {m6,m5,m4,m2}.
module hamming_receptor
    import hamming_rx_ctrl_pkg::*;
(
    input  logic [CW_LEN-1:0]   m_in,
    output logic [DATA_LEN-1:0] d_out
);

    logic [2:0] w_syn;

    always_comb begin
        w_syn = syndrome(m_in);
        d_out = {m_in[6], m_in[5], m_in[4], m_in[2]};
        // Syndromes 001/010/100 point at check bits: data stays as is.
        case (w_syn)
            3'b111:  d_out[3] = ~m_in[6];
            3'b110:  d_out[2] = ~m_in[5];
            3'b101:  d_out[1] = ~m_in[4];
            3'b011:  d_out[0] = ~m_in[2];
            default: ;
        endcase
    end

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Serial Hamming(7,4) receive controller: collects a 7-bit
// codeword MSB first, corrects it and counts erroneous frames.
module hamming_rx_ctrl
    import hamming_rx_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr_cnt,
    output logic [CNT_W-1:0] o_err_count,
    hamming_rx_ctrl_if.slave bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_cnt;
    logic [CW_LEN-1:0]   r_sr;
    logic [DATA_LEN-1:0] r_d_out;
    logic                r_err_flag;
    logic [CNT_W-1:0]    r_err_cnt;

    logic                w_accept;
    logic                w_abort;
    logic                w_last;
    logic [CW_LEN-1:0]   w_sr_nxt;
    logic [DATA_LEN-1:0] w_data;
    logic [2:0]          w_syn;

    assign w_abort  = (r_state == SHIFT) && bus.start;
    assign w_accept = (r_state == SHIFT) && bus.in_valid && !bus.start;
    assign w_last   = w_accept && (r_cnt == 3'(CW_LEN - 1));
    assign w_sr_nxt = {r_sr[CW_LEN-2:0], bus.in_bit};
    assign w_syn    = syndrome(w_sr_nxt);

    // Decode the completed word on the accepting edge so that d_out
    // is already valid during the DONE cycle alongside d_valid.
    hamming_receptor u_dec (
        .m_in  (w_sr_nxt),
        .d_out (w_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (r_state != IDLE);
        bus.d_valid = (r_state == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_sr       <= '0;
            r_d_out    <= '0;
            r_err_flag <= 1'b0;
        end else if ((r_state == IDLE && bus.start) || w_abort) begin
            r_cnt <= '0;
            r_sr  <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 3'd1;
            r_sr  <= w_sr_nxt;
            if (w_last) begin
                r_d_out    <= w_data;
                r_err_flag <= |w_syn;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_cnt) begin
            r_err_cnt <= '0;
        end else if (r_state == DONE && r_err_flag &&
                     r_err_cnt != {CNT_W{1'b1}}) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.d_out    = r_d_out;
    assign bus.err_flag = r_err_flag;
    assign o_err_count  = r_err_cnt;

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Randomized self-checking bench for hamming_rx_ctrl against
// a nearest-codeword reference decoder.
module tb_hamming_rx_ctrl;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [CNT_W-1:0] cnt;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               pulses = 0;
    int               m_cnt = 0;

    hamming_rx_ctrl_if bus ();

    hamming_rx_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clr_cnt   (clr),
        .o_err_count (cnt),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.d_valid === 1'b1) pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] syn_of(input logic [6:0] m);
        return {^(m & 7'b1111000), ^(m & 7'b1100110), ^(m & 7'b1010101)};
    endfunction

    // Hamming(7,4) is perfect: every word is within distance 1 of a codeword
    function automatic logic [3:0] ref_data(input logic [6:0] m);
        logic [6:0] c;
        for (int i = -1; i < 7; i++) begin
            c = m;
            if (i >= 0) c[i] = ~c[i];
            if (syn_of(c) == 3'b000) return {c[6], c[5], c[4], c[2]};
        end
        return 4'bxxxx;
    endfunction

    function automatic void ref_count(input logic err, input logic clr_hit);
        if (clr_hit) m_cnt = 0;
        else if (err && m_cnt < CMAX) m_cnt++;
    endfunction

    task automatic run_frame(input logic [6:0] cw, input int gap_pos,
                             input int gap_len, input logic clr_done,
                             output logic dv, output logic [3:0] dq,
                             output logic ef, output int early);
        int p0;
        p0 = pulses;
        bus.start    = 1'b1;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_bit   = 1'($urandom_range(0, 1));
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == gap_pos) begin
                repeat (gap_len) begin
                    bus.in_valid = 1'b0;
                    bus.in_bit   = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            bus.in_valid = 1'b1;
            bus.in_bit   = cw[6-i];
            tick();
        end
        early        = pulses - p0;
        dv           = bus.d_valid;
        dq           = bus.d_out;
        ef           = bus.err_flag;
        clr          = clr_done;
        bus.start    = 1'($urandom_range(0, 1));
        bus.in_valid = 1'($urandom_range(0, 1));
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        clr          = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
        tick(); tick();
        rst = 1'b0;
        m_cnt = 0;
        n_cmp++;
        if ({bus.d_out, bus.d_valid, bus.err_flag, bus.busy, cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset: got d_out=%h dv=%b ef=%b busy=%b cnt=%0d want all 0",
                     bus.d_out, bus.d_valid, bus.err_flag, bus.busy, cnt);
        end
    endtask

    task automatic test_fixed(input string nm, input logic [6:0] cw,
                              input logic [3:0] exp_d, input logic exp_e);
        logic dv, ef; logic [3:0] dq; int early, p0;
        p0 = pulses;
        run_frame(cw, 7, 0, 1'b0, dv, dq, ef, early);
        ref_count(exp_e, 1'b0);
        n_cmp++;
        if (dv !== 1'b1 || early != 0 || dq !== exp_d || ef !== exp_e) begin
            n_bad++;
            $display("FAIL %s: got dv=%b early=%0d d=%b ef=%b want dv=1 early=0 d=%b ef=%b",
                     nm, dv, early, dq, ef, exp_d, exp_e);
        end
        n_cmp++;
        if (cnt !== CNT_W'(m_cnt) || pulses - p0 != 1) begin
            n_bad++;
            $display("FAIL %s_cnt: got cnt=%0d pulses=%0d want cnt=%0d pulses=1",
                     nm, cnt, pulses - p0, m_cnt);
        end
    endtask

    task automatic test_gapped();
        logic dv, ef; logic [3:0] dq; int early, p0;
        run_frame(7'b1110101, 3, 3, 1'b0, dv, dq, ef, early);
        ref_count(1'b1, 1'b0);
        n_cmp++;
        if (dv !== 1'b1 || early != 0 || dq !== 4'b1011 || ef !== 1'b1) begin
            n_bad++;
            $display("FAIL gapped: got dv=%b early=%0d d=%b ef=%b want 1 0 1011 1",
                     dv, early, dq, ef);
        end
        // abort after 4 bits; restart strobe carries a discarded bit
        p0 = pulses;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_bit = 1'b1; tick();
        end
        bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.start = 1'b1; tick();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = (i % 2 == 0);
            tick();
            n_cmp++;
            if (i < 6 && bus.d_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_dv: got dv=%b at bit %0d want 0", bus.d_valid, i);
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.d_valid !== 1'b1 || bus.d_out !== 4'b1011 || bus.err_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_fresh: got dv=%b d=%b ef=%b want 1 1011 0",
                     bus.d_valid, bus.d_out, bus.err_flag);
        end
        tick();
        n_cmp++;
        if (pulses - p0 != 1) begin
            n_bad++;
            $display("FAIL abort_pulses: got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_saturation_clear();
        logic dv, ef; logic [3:0] dq; int early;
        clr = 1'b1; tick(); clr = 1'b0;
        m_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            run_frame(7'b1010100, 7, 0, 1'b0, dv, dq, ef, early);
            ref_count(1'b1, 1'b0);
        end
        n_cmp++;
        if (cnt !== 2'd3 || m_cnt != 3) begin
            n_bad++;
            $display("FAIL saturate: got %0d want 3", cnt);
        end
        run_frame(7'b1110101, 7, 0, 1'b1, dv, dq, ef, early);
        ref_count(1'b1, 1'b1);
        n_cmp++;
        if (cnt !== 2'd0 || ef !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_priority: got cnt=%0d ef=%b want 0 1", cnt, ef);
        end
    endtask

    task automatic test_rst_midframe();
        int p0;
        p0 = pulses;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_bit = 1'($urandom_range(0, 1)); tick();
        end
        rst = 1'b1; tick(); rst = 1'b0;
        m_cnt = 0;
        n_cmp++;
        if ({bus.d_out, bus.d_valid, bus.err_flag, bus.busy, cnt} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: got d=%h dv=%b ef=%b busy=%b cnt=%0d want all 0",
                     bus.d_out, bus.d_valid, bus.err_flag, bus.busy, cnt);
        end
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; bus.in_bit = 1'($urandom_range(0, 1)); tick();
        end
        bus.in_valid = 1'b0;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || pulses != p0 || bus.d_out !== 4'h0) begin
            n_bad++;
            $display("FAIL rst_ignore: got busy=%b pulses=%0d d=%h want 0 0 0",
                     bus.busy, pulses - p0, bus.d_out);
        end
    endtask

    task automatic test_random();
        logic dv, ef; logic [3:0] dq, exp_d; logic [6:0] cw;
        int early, gp, gl; logic c;
        for (int k = 0; k < 40; k++) begin
            cw    = 7'($urandom);
            gp    = $urandom_range(0, 7);
            gl    = $urandom_range(0, 4);
            c     = ($urandom_range(0, 7) == 0);
            exp_d = ref_data(cw);
            run_frame(cw, gp, gl, c, dv, dq, ef, early);
            ref_count(syn_of(cw) != 3'b000, c);
            n_cmp++;
            if (dv !== 1'b1 || early != 0 || dq !== exp_d ||
                ef !== (syn_of(cw) != 3'b000) || cnt !== CNT_W'(m_cnt)) begin
                n_bad++;
                $display("FAIL random[%0d] cw=%b: got dv=%b early=%0d d=%b ef=%b cnt=%0d want d=%b cnt=%0d",
                         k, cw, dv, early, dq, ef, cnt, exp_d, m_cnt);
            end
            repeat (2) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_bit   = 1'($urandom_range(0, 1));
                tick();
            end
            bus.in_valid = 1'b0;
            n_cmp++;
            if (bus.d_out !== exp_d || bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d]: got d=%b busy=%b want d=%b busy=0",
                         k, bus.d_out, bus.busy, exp_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed("clean", 7'b1010101, 4'b1011, 1'b0);
        test_fixed("data_err", 7'b1110101, 4'b1011, 1'b1);
        test_fixed("check_err", 7'b1010100, 4'b1011, 1'b1);
        test_gapped();
        test_saturation_clear();
        test_rst_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hamming_rx_ctrl.md
HAMMING_RX_CTRL -- requirements
Module: hamming_rx_ctrl

Interface
REQ-001 Parameter: CNT_W, default 8, width of the corrected-error counter.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  frame-start strobe; begins collection of one 7-bit codeword.
REQ-005 in_bit  input  1  serial codeword bit.
REQ-006 in_valid  input  1  in_bit qualifier; one bit accepted per cycle when high in SHIFT.
REQ-007 clr_cnt  input  1  synchronous clear of err_count.
REQ-008 d_out  output  4  corrected data nibble, registered, held until the next frame completes.
REQ-009 d_valid  output  1  one-cycle pulse when d_out and err_flag update.
REQ-010 err_flag  output  1  high when the last decoded codeword had a nonzero syndrome.
REQ-011 err_count  output  CNT_W  saturating count of codewords with a nonzero syndrome.
REQ-012 busy  output  1  high in SHIFT and DONE.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 -> SHIFT with bit counter=0; in_valid is ignored, including when it coincides with start.
REQ-015 SHIFT: each cycle with in_valid=1 shifts in_bit into a 7-bit register, MSB first (first bit -> m[6], last -> m[0]), and increments the counter.
REQ-016 SHIFT: in_valid=0 -> hold; no timeout.
REQ-017 SHIFT: start=1 aborts the frame: counter=0, shift register cleared, in_bit that cycle discarded, no d_valid, remain SHIFT.
REQ-018 SHIFT: acceptance of the 7th bit -> DONE next cycle.
REQ-019 Syndrome c[2]=m3^m4^m5^m6, c[1]=m1^m2^m5^m6, c[0]=m0^m2^m4^m6; data bits m6,m5,m4,m2 are inverted when c = 111,110,101,011 respectively; other nonzero syndromes indicate a check-bit error and leave data unchanged.
REQ-020 DONE (one cycle): d_out <= {m6,m5,m4,m2} after correction, err_flag <= (c!=0), d_valid=1; then -> IDLE. start and in_valid are ignored in DONE.
REQ-021 Latency: d_valid asserts exactly one cycle after the clock edge that accepts the 7th bit; minimum frame period is 9 cycles (start, 7 bits, DONE).
REQ-022 err_count increments by 1 on a DONE cycle with c!=0; it saturates at 2^CNT_W-1 without wrapping.
REQ-023 clr_cnt=1 sets err_count to 0 and has priority over a coincident increment.
REQ-024 d_out and err_flag change only in DONE or on reset.

Reset
REQ-025 rst=1 at a clock edge: state=IDLE, counter=0, shift register=0, d_out=0, d_valid=0, err_flag=0, err_count=0, busy=0.
REQ-026 rst mid-frame (SHIFT or DONE) discards the partial frame and produces no d_valid; rst overrides all other inputs.

Structure
REQ-027 A shared package/include holds CW_LEN=7, DATA_LEN=4, and the IDLE/SHIFT/DONE state encodings.
REQ-028 Data correction uses an instance of the existing combinational decoder hamming_receptor (m_in[6:0] -> d_out[3:0]) as the single sub-module; the controller computes the syndrome locally for err_flag.

Verification
REQ-029 Clean frame: start, then bits 1,0,1,0,1,0,1 (7'b1010101) -> d_valid 1 cycle after the 7th bit, d_out=4'b1011, err_flag=0, err_count unchanged.
REQ-030 Data error: 7'b1110101 -> d_out=4'b1011, err_flag=1, err_count +1.
REQ-031 Check-bit error: 7'b1010100 -> syndrome 001, d_out=4'b1011, err_flag=1.
REQ-032 Gapped input: in_valid low for 3 cycles between bits 3 and 4 -> result matches the gapless case with d_valid delayed 3 cycles; start after bit 4 -> no d_valid, next 7 bits decoded as a fresh frame.
REQ-033 Saturation/clear: CNT_W=2 with 5 error frames -> err_count=3; clr_cnt coincident with an error DONE -> err_count=0.
REQ-034 Reset mid-frame: rst after 4 bits -> all outputs 0, busy=0, bits after rst ignored until start.
